spi_frame_sequencer: RTL and testbench
======================================

Name: spi_frame_sequencer

Overview:
Frame-level controller between the byte-level SPI shifter and the stepgen/wdt/output datapath of the pluto stepper firmware. It counts received bytes and decodes the byte index into shadow register writes, which are committed to the live outputs atomically, and only for a complete, well-formed frame. It also snapshots positions and inputs at frame start so the readback is coherent, and it gates the watchdog kick on good frames.

Parameters:
W, 10, integer bits of stepgen position
F, 11, fractional bits; velocity width is F+1
T, 4, dirtime/steptime width
FRAME_LEN, 20, exact byte count of a valid frame

Ports:
clk  in  1  system clock
nRESET  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse, SSEL falling edge (synchronized)
frame_end  in  1  one-cycle pulse, SSEL rising edge (synchronized)
byte_valid  in  1  one-cycle pulse, rx_byte complete
rx_byte  in  8  received byte
tx_byte  out  8  byte to load for the current index
pos0..pos3  in  W+F each  stepgen positions
din  in  16  digital inputs
vel0..vel3  out  F+1 each  live velocities
dout  out  10  live digital outputs
dirtime, steptime  out  T each  live timing
tap  out  2  live tap select
spolarity  out  1  step polarity
wdt_kick  out  1  one-cycle pulse on a good commit with the enable bit set
frame_err  out  1  sticky error flag

Behaviour:
- Reset: all live outputs, shadows, snapshots, counters and tx_byte go to 0; state goes to IDLE; wdt_kick=0; frame_err=0.
- States:
  - IDLE: frame_start -> RECV.
  - RECV: frame_end -> COMMIT if idx==FRAME_LEN and no overrun, else IDLE with frame_err=1 and err_cnt+1. frame_start while in RECV aborts the frame (frame_err=1, err_cnt+1) and restarts RECV.
  - COMMIT: lasts 1 cycle, then -> IDLE.
- Frame start: idx cleared to 0. pos0..3 and din are captured into snapshot registers on that same edge. tx_byte shows the byte-0 value on the next cycle.
- byte_valid in RECV, with idx<FRAME_LEN: the byte is written into the shadow slot for idx; idx increments; tx_byte is updated the next cycle for the new idx.
- byte_valid in RECV, with idx==FRAME_LEN: idx saturates and the overrun flag is set.
- byte_valid in IDLE or COMMIT: ignored.
- RX map (little-endian 16-bit words):
  - bytes 0-1 vel0, 2-3 vel1, 4-5 vel2, 6-7 vel3; only bits [F:0] are kept.
  - bytes 8-9: dout = {b9[1:0], b8}; b9[6] is wdt_en.
  - byte 10: spolarity=b10[7], dirtime=b10[T-1:0].
  - byte 11: tap=b11[7:6], steptime=b11[T-1:0].
  - bytes 12-19: ignored.
- TX map: for k=0..3, bytes 4k..4k+3 are snap_pos_k, zero-extended to 32 bits, LE. Bytes 16-17 are snap_din LE. Byte 18 = {frame_err, 2'b0, err_cnt[4:0]}. Byte 19 = good_cnt[7:0]. Indices at or above FRAME_LEN give 8'h00.
- COMMIT: all shadows are copied to the live outputs on one edge, so no partial update is ever visible. good_cnt increments (8-bit, wraps). frame_err clears. wdt_kick=1 for this cycle iff the shadow wdt_en is set.
- err_cnt saturates at 31 and clears only on reset.
- frame_start and frame_end in the same cycle: frame_end is evaluated first. In RECV this gives a commit or an error per the rule above, and the next state is RECV with idx=0 (a new snapshot is taken); the commit still happens.
- Shadows are not cleared between frames; an aborted frame never reaches the live outputs.

Decomposition:
- Package pluto_spi_pkg holds: FRAME_LEN; byte-index constants (IDX_VEL0..IDX_TIMING, IDX_STATUS=18, IDX_GOODCNT=19); the state encoding IDLE/RECV/COMMIT; status bit positions.
- One natural sub-module: spi_tx_mux. It holds the snapshot registers and the index-to-byte readback mux, so the decode logic is isolated from the FSM.

Test Plan:
- Reset mid-RECV after 5 bytes -> all outputs 0, IDLE; a subsequent full frame commits normally.
- Full 20-byte frame, b0=34 b1=12, b9=8'h40 -> vel0=12'h234 after COMMIT, wdt_kick high exactly 1 cycle, good_cnt=1, frame_err=0.
- 19-byte frame then frame_end -> live outputs unchanged, frame_err=1, byte 18 read on the next frame = 8'h81.
- 22-byte frame -> overrun, no commit, err_cnt+1; tx_byte for extra bytes = 8'h00.
- pos0=21'h1ABCDE at frame_start, pos0 changed mid-frame -> readback bytes 0-3 = DE BC 1A 00 (snapshot held).
- frame_start and frame_end in the same cycle after 20 bytes -> commit occurs, new frame starts with idx=0.

Source files
------------

// File: rtl/pluto_spi_pkg.sv
// Shared constants and state encoding for the pluto SPI frame sequencer.
package pluto_spi_pkg;

  localparam int unsigned FRAME_LEN    = 20;

  // Byte indices within a frame
  localparam int unsigned IDX_VEL0     = 0;
  localparam int unsigned IDX_VEL1     = 2;
  localparam int unsigned IDX_VEL2     = 4;
  localparam int unsigned IDX_VEL3     = 6;
  localparam int unsigned IDX_DOUT_LO  = 8;
  localparam int unsigned IDX_DOUT_HI  = 9;
  localparam int unsigned IDX_TIMING   = 10;
  localparam int unsigned IDX_TAP      = 11;
  localparam int unsigned IDX_DIN      = 16;
  localparam int unsigned IDX_STATUS   = 18;
  localparam int unsigned IDX_GOODCNT  = 19;

  // Bit positions inside control/status bytes
  localparam int unsigned WDT_EN_BIT   = 6;
  localparam int unsigned SPOL_BIT     = 7;
  localparam int unsigned TAP_LSB      = 6;
  localparam int unsigned STAT_ERR_BIT = 7;

  localparam int unsigned ERR_CNT_W    = 5;
  localparam int unsigned GOOD_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_tx_mux.sv
// Frame-start snapshot of positions/inputs and index-to-byte readback mux.
module spi_tx_mux #(
  parameter int unsigned PW        = 21,
  parameter int unsigned IW        = 5,
  parameter int unsigned FRAME_LEN = 20
) (
  input  logic          clk,
  input  logic          nRESET,
  input  logic          snap_en,
  input  logic [PW-1:0] pos [4],
  input  logic [15:0]   din,
  input  logic [IW-1:0] idx,
  input  logic          frame_err,
  input  logic [4:0]    err_cnt,
  input  logic [7:0]    good_cnt,
  output logic [7:0]    tx_byte
);
  import pluto_spi_pkg::*;

  logic [PW-1:0] snap_pos [4];
  logic [15:0]   snap_din;
  logic [PW-1:0] pos_sel_c;
  logic [15:0]   din_sel_c;
  logic [31:0]   word_c;
  logic [7:0]    byte_c;

  // Capture positions and inputs on the frame-start edge
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      for (int k = 0; k < 4; k++) snap_pos[k] <= '0;
      snap_din <= '0;
    end else if (snap_en) begin
      for (int k = 0; k < 4; k++) snap_pos[k] <= pos[k];
      snap_din <= din;
    end
  end

  // Select the byte for idx; at frame start read straight from the inputs being captured
  always_comb begin
    pos_sel_c = snap_en ? pos[idx[3:2]] : snap_pos[idx[3:2]];
    din_sel_c = snap_en ? din : snap_din;
    word_c    = 32'(pos_sel_c);
    byte_c    = 8'h00;
    if (32'(idx) >= FRAME_LEN) begin
      byte_c = 8'h00;
    end else if (32'(idx) < IDX_DIN) begin
      byte_c = 8'(word_c >> {idx[1:0], 3'b000});
    end else begin
      case (32'(idx))
        IDX_DIN:     byte_c = din_sel_c[7:0];
        IDX_DIN + 1: byte_c = din_sel_c[15:8];
        IDX_STATUS:  byte_c = {frame_err, 2'b00, err_cnt};
        IDX_GOODCNT: byte_c = good_cnt;
        default:     byte_c = 8'h00;
      endcase
    end
  end

  // Registered readback byte
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) tx_byte <= 8'h00;
    else         tx_byte <= byte_c;
  end

endmodule

// File: rtl/spi_frame_sequencer.sv
// Frame-level SPI controller: shadow decode, atomic commit, snapshot readback, watchdog gating.
module spi_frame_sequencer #(
  parameter int unsigned W         = 10,
  parameter int unsigned F         = 11,
  parameter int unsigned T         = 4,
  parameter int unsigned FRAME_LEN = pluto_spi_pkg::FRAME_LEN
) (
  input  logic           clk,
  input  logic           nRESET,
  input  logic           frame_start,
  input  logic           frame_end,
  input  logic           byte_valid,
  input  logic [7:0]     rx_byte,
  output logic [7:0]     tx_byte,
  input  logic [W+F-1:0] pos0,
  input  logic [W+F-1:0] pos1,
  input  logic [W+F-1:0] pos2,
  input  logic [W+F-1:0] pos3,
  input  logic [15:0]    din,
  output logic [F:0]     vel0,
  output logic [F:0]     vel1,
  output logic [F:0]     vel2,
  output logic [F:0]     vel3,
  output logic [9:0]     dout,
  output logic [T-1:0]   dirtime,
  output logic [T-1:0]   steptime,
  output logic [1:0]     tap,
  output logic           spolarity,
  output logic           wdt_kick,
  output logic           frame_err
);
  import pluto_spi_pkg::*;

  localparam int unsigned PW = W + F;
  localparam int unsigned VW = F + 1;
  localparam int unsigned IW = $clog2(FRAME_LEN + 1);

  state_t          state, state_next;
  logic [IW-1:0]   idx, idx_next_c;
  logic            overrun, overrun_next_c;
  logic            start_c, commit_c, error_c, wr_c, good_c;
  logic [VW-1:0]   vel_sh [4];
  logic [9:0]      dout_sh;
  logic            wdt_en_sh, spol_sh;
  logic [T-1:0]    dirtime_sh, steptime_sh;
  logic [1:0]      tap_sh;
  logic [ERR_CNT_W-1:0]  err_cnt;
  logic [GOOD_CNT_W-1:0] good_cnt;
  logic [PW-1:0]   pos_arr [4];

  assign pos_arr[0] = pos0;
  assign pos_arr[1] = pos1;
  assign pos_arr[2] = pos2;
  assign pos_arr[3] = pos3;

  assign good_c = (idx == IW'(FRAME_LEN)) && !overrun;
  assign wr_c   = (state == RECV) && byte_valid && !frame_start && !frame_end;

  // State register
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= state_next;
  end

  // Next state and frame events; frame_end is resolved before a coincident frame_start
  always_comb begin
    state_next = state;
    start_c    = 1'b0;
    commit_c   = 1'b0;
    error_c    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          start_c    = 1'b1;
          state_next = RECV;
        end
      end
      RECV: begin
        if (frame_end) begin
          if (good_c) begin
            commit_c   = 1'b1;
            state_next = COMMIT;
          end else begin
            error_c    = 1'b1;
            state_next = IDLE;
          end
          if (frame_start) begin
            start_c    = 1'b1;
            state_next = RECV;
          end
        end else if (frame_start) begin
          error_c = 1'b1;
          start_c = 1'b1;
        end
      end
      COMMIT: begin
        state_next = IDLE;
        if (frame_start) begin
          start_c    = 1'b1;
          state_next = RECV;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte index and overrun tracking
  always_comb begin
    idx_next_c     = idx;
    overrun_next_c = overrun;
    if (start_c) begin
      idx_next_c     = '0;
      overrun_next_c = 1'b0;
    end else if (wr_c) begin
      if (idx < IW'(FRAME_LEN)) idx_next_c     = idx + 1'b1;
      else                      overrun_next_c = 1'b1;
    end
  end

  // Index registers
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      idx     <= idx_next_c;
      overrun <= overrun_next_c;
    end
  end

  // Shadow register decode; shadows persist across frames
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      for (int k = 0; k < 4; k++) vel_sh[k] <= '0;
      dout_sh     <= '0;
      wdt_en_sh   <= 1'b0;
      spol_sh     <= 1'b0;
      dirtime_sh  <= '0;
      steptime_sh <= '0;
      tap_sh      <= '0;
    end else if (wr_c && (idx < IW'(FRAME_LEN))) begin
      if (32'(idx) < IDX_DOUT_LO) begin
        if (idx[0]) vel_sh[idx[2:1]][VW-1:8] <= rx_byte[VW-9:0];
        else        vel_sh[idx[2:1]][7:0]    <= rx_byte;
      end else begin
        case (32'(idx))
          IDX_DOUT_LO: dout_sh[7:0] <= rx_byte;
          IDX_DOUT_HI: begin
            dout_sh[9:8] <= rx_byte[1:0];
            wdt_en_sh    <= rx_byte[WDT_EN_BIT];
          end
          IDX_TIMING: begin
            spol_sh    <= rx_byte[SPOL_BIT];
            dirtime_sh <= rx_byte[T-1:0];
          end
          IDX_TAP: begin
            tap_sh      <= rx_byte[TAP_LSB +: 2];
            steptime_sh <= rx_byte[T-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  // Atomic commit of live outputs, frame counters and watchdog kick
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      vel0      <= '0;
      vel1      <= '0;
      vel2      <= '0;
      vel3      <= '0;
      dout      <= '0;
      dirtime   <= '0;
      steptime  <= '0;
      tap       <= '0;
      spolarity <= 1'b0;
      wdt_kick  <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
      good_cnt  <= '0;
    end else begin
      wdt_kick <= commit_c & wdt_en_sh;
      if (commit_c) begin
        vel0      <= vel_sh[0];
        vel1      <= vel_sh[1];
        vel2      <= vel_sh[2];
        vel3      <= vel_sh[3];
        dout      <= dout_sh;
        dirtime   <= dirtime_sh;
        steptime  <= steptime_sh;
        tap       <= tap_sh;
        spolarity <= spol_sh;
        good_cnt  <= good_cnt + 1'b1;
        frame_err <= 1'b0;
      end else if (error_c) begin
        frame_err <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  spi_tx_mux #(
    .PW        (PW),
    .IW        (IW),
    .FRAME_LEN (FRAME_LEN)
  ) u_tx_mux (
    .clk       (clk),
    .nRESET    (nRESET),
    .snap_en   (start_c),
    .pos       (pos_arr),
    .din       (din),
    .idx       (idx_next_c),
    .frame_err (frame_err),
    .err_cnt   (err_cnt),
    .good_cnt  (good_cnt),
    .tx_byte   (tx_byte)
  );

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Scoreboard bench for spi_frame_sequencer.
module tb_spi_frame_sequencer;

  localparam int unsigned W  = 10;
  localparam int unsigned F  = 11;
  localparam int unsigned T  = 4;
  localparam int unsigned FL = 20;
  localparam int unsigned PW = W + F;
  localparam int unsigned VW = F + 1;

  logic          clk = 1'b0;
  logic          nRESET = 1'b0;
  logic          frame_start = 1'b0;
  logic          frame_end = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    rx_byte;
  logic [7:0]    tx_byte;
  logic [PW-1:0] pos [4];
  logic [15:0]   din;
  logic [VW-1:0] vel0, vel1, vel2, vel3;
  logic [9:0]    dout;
  logic [T-1:0]  dirtime, steptime;
  logic [1:0]    tap;
  logic          spolarity, wdt_kick, frame_err;

  spi_frame_sequencer #(.W(W), .F(F), .T(T), .FRAME_LEN(FL)) dut (
    .clk(clk), .nRESET(nRESET), .frame_start(frame_start), .frame_end(frame_end),
    .byte_valid(byte_valid), .rx_byte(rx_byte), .tx_byte(tx_byte),
    .pos0(pos[0]), .pos1(pos[1]), .pos2(pos[2]), .pos3(pos[3]), .din(din),
    .vel0(vel0), .vel1(vel1), .vel2(vel2), .vel3(vel3), .dout(dout),
    .dirtime(dirtime), .steptime(steptime), .tap(tap), .spolarity(spolarity),
    .wdt_kick(wdt_kick), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]    m_sh [12];
  logic [PW-1:0] m_snap [4];
  logic [15:0]   m_snap_din;
  logic [VW-1:0] m_vel [4];
  logic [9:0]    m_dout;
  logic [T-1:0]  m_dir, m_step;
  logic [1:0]    m_tap;
  logic          m_spol, m_err;
  logic [4:0]    m_errcnt;
  logic [7:0]    m_good;
  int            m_idx;
  bit            m_ovr, m_recv;

  logic [7:0]    tx_q [$];
  logic [7:0]    last_tx;
  int            n_tests, n_fail;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_tx(input int i);
    logic [31:0] w;
    if (i >= int'(FL)) return 8'h00;
    if (i < 16) begin
      w = 32'(m_snap[i / 4]);
      return 8'(w >> (8 * (i % 4)));
    end
    case (i)
      16: return m_snap_din[7:0];
      17: return m_snap_din[15:8];
      18: return {m_err, 2'b00, m_errcnt};
      default: return m_good;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 12; k++) m_sh[k] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      m_snap[k] = '0;
      m_vel[k]  = '0;
    end
    m_snap_din = '0; m_dout = '0; m_dir = '0; m_step = '0; m_tap = '0;
    m_spol = 1'b0; m_err = 1'b0; m_errcnt = '0; m_good = '0;
    m_idx = 0; m_ovr = 1'b0; m_recv = 1'b0;
  endtask

  task automatic model_error();
    m_err = 1'b1;
    if (m_errcnt != 5'd31) m_errcnt = m_errcnt + 5'd1;
    m_recv = 1'b0;
  endtask

  task automatic model_commit(output bit kick);
    for (int k = 0; k < 4; k++) m_vel[k] = VW'({m_sh[2*k+1], m_sh[2*k]});
    m_dout = {m_sh[9][1:0], m_sh[8]};
    m_spol = m_sh[10][7];
    m_dir  = m_sh[10][T-1:0];
    m_tap  = m_sh[11][7:6];
    m_step = m_sh[11][T-1:0];
    kick   = m_sh[9][6];
    m_good = m_good + 8'd1;
    m_err  = 1'b0;
    m_recv = 1'b0;
  endtask

  task automatic model_snapshot();
    for (int k = 0; k < 4; k++) m_snap[k] = pos[k];
    m_snap_din = din;
    m_idx = 0; m_ovr = 1'b0; m_recv = 1'b1;
  endtask

  task automatic pop_tx(input string tag);
    if (tx_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: scoreboard empty, got 0x%0h", tag, tx_byte);
    end else begin
      last_tx = tx_byte;
      check(tag, 32'(tx_byte), 32'(tx_q.pop_front()));
    end
  endtask

  task automatic check_live();
    check("vel0", 32'(vel0), 32'(m_vel[0]));
    check("vel1", 32'(vel1), 32'(m_vel[1]));
    check("vel2", 32'(vel2), 32'(m_vel[2]));
    check("vel3", 32'(vel3), 32'(m_vel[3]));
    check("dout", 32'(dout), 32'(m_dout));
    check("timing", 32'({spolarity, tap, dirtime, steptime}), 32'({m_spol, m_tap, m_dir, m_step}));
    check("frame_err", 32'(frame_err), 32'(m_err));
  endtask

  task automatic new_inputs();
    for (int k = 0; k < 4; k++) pos[k] = PW'($urandom);
    din = 16'($urandom);
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    if (m_recv) model_error();
    model_snapshot();
    tx_q.push_back(exp_tx(0));
    tick();
    frame_start = 1'b0;
    pop_tx("tx_start");
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit active;
    active = m_recv;
    rx_byte = b;
    byte_valid = 1'b1;
    if (active) begin
      if (m_idx < int'(FL)) begin
        if (m_idx < 12) m_sh[m_idx] = b;
        m_idx++;
      end else begin
        m_ovr = 1'b1;
      end
      tx_q.push_back(exp_tx(m_idx));
    end
    tick();
    byte_valid = 1'b0;
    if (active) pop_tx("tx_byte");
  endtask

  task automatic end_frame(input bit with_start);
    bit kick;
    kick = 1'b0;
    frame_end = 1'b1;
    frame_start = with_start;
    if (m_recv) begin
      if (m_idx == int'(FL) && !m_ovr) model_commit(kick);
      else model_error();
    end
    if (with_start) begin
      model_snapshot();
      tx_q.push_back(exp_tx(0));
    end
    tick();
    frame_end = 1'b0;
    frame_start = 1'b0;
    check_live();
    check("wdt_kick", 32'(wdt_kick), 32'(kick));
    if (with_start) pop_tx("tx_restart");
    tick();
    check("wdt_kick_off", 32'(wdt_kick), 32'h0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; rx_byte = 8'h00; last_tx = 8'h00;
    for (int k = 0; k < 4; k++) pos[k] = '0;
    din = '0;
    model_reset();

    // Reset values
    repeat (2) tick();
    check("rst_tx", 32'(tx_byte), 32'h0);
    check_live();
    check("rst_kick", 32'(wdt_kick), 32'h0);
    nRESET = 1'b1;
    tick();

    // Warm-up good frame so live outputs are non-zero
    new_inputs();
    start_frame();
    for (int i = 0; i < 20; i++) send_byte(8'($urandom));
    end_frame(1'b0);

    // Asynchronous reset after 5 bytes of a frame
    new_inputs();
    start_frame();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    nRESET = 1'b0;
    #2;
    model_reset();
    tx_q.delete();
    check("rrst_tx", 32'(tx_byte), 32'h0);
    check_live();
    tick();
    nRESET = 1'b1;
    tick();

    // Frame with known velocity and watchdog enable
    new_inputs();
    start_frame();
    for (int i = 0; i < 20; i++) begin
      if (i == 0)      send_byte(8'h34);
      else if (i == 1) send_byte(8'h12);
      else if (i == 9) send_byte(8'h40);
      else             send_byte(8'($urandom));
    end
    end_frame(1'b0);
    check("vel0_234", 32'(vel0), 32'h234);

    // Short frame: error, live outputs untouched
    new_inputs();
    start_frame();
    for (int i = 0; i < 19; i++) send_byte(8'($urandom));
    end_frame(1'b0);
    check("short_err", 32'(frame_err), 32'h1);

    // Snapshot coherence plus status readback, ending with coincident end/start
    new_inputs();
    pos[0] = 21'h1ABCDE;
    start_frame();
    check("snap_b0", 32'(last_tx), 32'hDE);
    pos[0] = 21'h00F0F0;
    for (int i = 0; i < 20; i++) begin
      send_byte(8'($urandom));
      if (i == 0)  check("snap_b1", 32'(last_tx), 32'hBC);
      if (i == 1)  check("snap_b2", 32'(last_tx), 32'h1A);
      if (i == 2)  check("snap_b3", 32'(last_tx), 32'h00);
      if (i == 17) check("status_b18", 32'(last_tx), 32'h81);
      if (i == 18) check("goodcnt_b19", 32'(last_tx), 32'h01);
    end
    end_frame(1'b1);
    check("coinc_err_clr", 32'(frame_err), 32'h0);

    // Overrun in the frame started by the coincident pulse
    for (int i = 0; i < 22; i++) begin
      send_byte(8'($urandom));
      if (i >= 19) check("ovr_tx_zero", 32'(last_tx), 32'h0);
    end
    end_frame(1'b0);
    check("ovr_err", 32'(frame_err), 32'h1);

    // Abort by a second frame_start, then a good frame
    new_inputs();
    start_frame();
    for (int i = 0; i < 7; i++) send_byte(8'($urandom));
    new_inputs();
    start_frame();
    for (int i = 0; i < 20; i++) send_byte(8'($urandom));
    end_frame(1'b0);

    // Status byte reflects accumulated errors; frame ends short
    new_inputs();
    start_frame();
    for (int i = 0; i < 19; i++) send_byte(8'($urandom));
    end_frame(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
